// File: rtl/booth_mult8_datapath.sv
// Radix-4 Booth datapath for the 8-bit sequential multiplier, driven by an external 0..5 step counter.
// Optional debug ports dbg_digit/dbg_acc are present only when MULT_STEP_DBG_EN is defined.
module booth_mult8_datapath #(
  parameter int SIGNED_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  cnt,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product,
  output logic        done,
  output logic        busy
`ifdef MULT_STEP_DBG_EN
  ,
  output logic [2:0]  dbg_digit,
  output logic [19:0] dbg_acc
`endif
);

  logic [19:0] acc_q, acc_d;
  logic [9:0]  mcand_q, mcand_d;
  logic [10:0] mplier_q, mplier_d;
  logic [15:0] product_q, product_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic        load, step, last, illegal;
  logic [9:0]  a_ext, b_ext;
  logic [2:0]  digit;
  logic [19:0] mc20, pp, pp_sh, acc_step;
  logic [3:0]  shamt;

  assign illegal = cnt[2] & cnt[1];
  assign load    = start && (cnt == 3'd0);
  assign step    = (cnt != 3'd0) && (cnt <= 3'd5);
  assign last    = (cnt == 3'd5);

  always_comb begin
    if (SIGNED_MODE != 0) begin
      a_ext = {{2{a[7]}}, a};
      b_ext = {{2{b[7]}}, b};
    end else begin
      a_ext = {2'b00, a};
      b_ext = {2'b00, b};
    end
  end

  // Booth digit kept in two's complement so it can be exposed directly for debug.
  always_comb begin
    digit = 3'b000;
    case (mplier_q[2:0])
      3'b001, 3'b010: digit = 3'b001;
      3'b011:         digit = 3'b010;
      3'b100:         digit = 3'b110;
      3'b101, 3'b110: digit = 3'b111;
      default:        digit = 3'b000;
    endcase
  end

  assign mc20 = {{10{mcand_q[9]}}, mcand_q};

  always_comb begin
    pp = 20'd0;
    case (digit)
      3'b001:  pp = mc20;
      3'b010:  pp = mc20 << 1;
      3'b110:  pp = -(mc20 << 1);
      3'b111:  pp = -mc20;
      default: pp = 20'd0;
    endcase
  end

  // Step k carries weight 4^(k-1); the shift is only meaningful while step is high.
  assign shamt    = {cnt - 3'd1, 1'b0};
  assign pp_sh    = pp << shamt;
  assign acc_step = acc_q + pp_sh;

  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (load) begin
      mcand_d  = a_ext;
      mplier_d = {b_ext, 1'b0};
      acc_d    = 20'd0;
      busy_d   = 1'b1;
    end else if (step) begin
      acc_d    = acc_step;
      mplier_d = {mplier_q[10], mplier_q[10], mplier_q[10:2]};
      if (last) begin
        product_d = acc_step[15:0];
        done_d    = 1'b1;
        busy_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= 20'd0;
      mcand_q   <= 10'd0;
      mplier_q  <= 11'd0;
      product_q <= 16'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign product = product_q;
  assign done    = done_q & ~illegal;
  assign busy    = busy_q;

`ifdef MULT_STEP_DBG_EN
  assign dbg_digit = step ? digit : 3'b000;
  assign dbg_acc   = acc_q;
`endif

endmodule

// File: tb/tb_booth_mult8_datapath.sv
// Directed bench for booth_mult8_datapath: unsigned and signed instances share stimulus and an upstream step-counter model.
module tb_booth_mult8_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = 8'd0;
  logic [7:0]  b = 8'd0;
  logic [2:0]  cnt, cnt_q;
  logic        ovr_en = 1'b0;
  logic [2:0]  ovr_val = 3'd0;
  logic [15:0] prod_u, prod_s;
  logic        done_u, done_s, busy_u, busy_s;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exps_q[$];

`ifdef MULT_STEP_DBG_EN
  logic [2:0]  dig_u, dig_s;
  logic [19:0] acc_u, acc_s;
`endif

  booth_mult8_datapath #(.SIGNED_MODE(0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start), .cnt(cnt), .a(a), .b(b),
    .product(prod_u), .done(done_u), .busy(busy_u)
`ifdef MULT_STEP_DBG_EN
    , .dbg_digit(dig_u), .dbg_acc(acc_u)
`endif
  );

  booth_mult8_datapath #(.SIGNED_MODE(1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start), .cnt(cnt), .a(a), .b(b),
    .product(prod_s), .done(done_s), .busy(busy_s)
`ifdef MULT_STEP_DBG_EN
    , .dbg_digit(dig_s), .dbg_acc(acc_s)
`endif
  );

  // Clock / reset and upstream step counter (0 idle, 1..5 steps)
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 3'd0;
    else if (!ovr_en) begin
      if (cnt_q == 3'd0) begin
        if (start) cnt_q <= 3'd1;
      end else if (cnt_q == 3'd5) cnt_q <= 3'd0;
      else cnt_q <= cnt_q + 3'd1;
    end
  end

  assign cnt = ovr_en ? ovr_val : cnt_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full operation; done is expected on the sixth edge counting the load edge.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp_u, input logic [15:0] exp_s);
    int edges;
    int busy_n;
    a = av; b = bv; start = 1'b1;
    exp_q.push_back(exp_u);
    exps_q.push_back(exp_s);
    tick();
    start = 1'b0;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    edges = 1; busy_n = 0;
    while (!done_u && edges < 20) begin
      if (busy_u) busy_n++;
      tick();
      edges++;
    end
    check({tag, "_lat"}, edges, 6);
    check({tag, "_busy_cycles"}, busy_n, 5);
    check({tag, "_done_s"}, {31'd0, done_s}, 1);
    check({tag, "_prod_u"}, {16'd0, prod_u}, {16'd0, exp_q.pop_front()});
    check({tag, "_prod_s"}, {16'd0, prod_s}, {16'd0, exps_q.pop_front()});
    check({tag, "_busy_end"}, {31'd0, busy_u}, 0);
    tick();
    check({tag, "_done_1cyc"}, {31'd0, done_u}, 0);
  endtask

  initial begin
    int edges;
    int extra;
    logic [15:0] held;

    rst = 1'b1;
    #12;
    check("rst_prod", {16'd0, prod_u}, 0);
    check("rst_done", {31'd0, done_u}, 0);
    check("rst_busy", {31'd0, busy_u}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Basic unsigned/signed products
    run_op("ff_ff",   8'hFF, 8'hFF, 16'hFE01, 16'h0001);
    run_op("m128sq",  8'h80, 8'h80, 16'h4000, 16'h4000);
    run_op("m1x127",  8'hFF, 8'h7F, 16'h7E81, 16'hFF81);
    run_op("127xm128",8'h7F, 8'h80, 16'h3F80, 16'hC080);
    run_op("zero",    8'h00, 8'hA5, 16'h0000, 16'h0000);
    run_op("a5x1",    8'hA5, 8'h01, 16'h00A5, 16'hFFA5);

    // Illegal count while idle: nothing moves, even with start high
    held = prod_u;
    ovr_en = 1'b1; ovr_val = 3'd6; start = 1'b1; a = 8'd9; b = 8'd9;
    tick();
    ovr_val = 3'd7;
    tick();
    check("ill_busy", {31'd0, busy_u}, 0);
    check("ill_done", {31'd0, done_u}, 0);
    check("ill_prod", {16'd0, prod_u}, {16'd0, held});
    start = 1'b0; ovr_en = 1'b0;
    tick();
    check("ill_after_busy", {31'd0, busy_u}, 0);

    // Start at cnt==2 is ignored
    a = 8'd3; b = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 8'd9; b = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 3;
    while (!done_u && edges < 20) begin tick(); edges++; end
    check("ign_lat", edges, 6);
    check("ign_prod", {16'd0, prod_u}, 32'h000C);
    check("ign_prod_s", {16'd0, prod_s}, 32'h000C);
    extra = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (done_u) extra++; end
    check("ign_no_extra_done", extra, 0);
    check("ign_busy", {31'd0, busy_u}, 0);

    // Illegal count in the done cycle masks done
    a = 8'd5; b = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    while (!done_u && edges < 20) begin
      if (cnt == 3'd5) begin
        tick();
        edges++;
        ovr_en = 1'b1; ovr_val = 3'd7;
        #1;
        break;
      end
      tick();
      edges++;
    end
    check("ill_done_mask", {31'd0, done_u}, 0);
    check("ill_done_prod", {16'd0, prod_u}, 32'h0019);
    ovr_en = 1'b0;
    tick();
    check("ill_done_after", {31'd0, done_u}, 0);

    // Reset mid-operation at cnt==3
    a = 8'd50; b = 8'd50; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_prod", {16'd0, prod_u}, 0);
    check("mid_rst_busy", {31'd0, busy_u}, 0);
    check("mid_rst_done", {31'd0, done_u}, 0);
    tick();
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (done_u) extra++; end
    check("mid_rst_no_done", extra, 0);
    run_op("after_rst", 8'd2, 8'd3, 16'h0006, 16'h0006);

    // Back-to-back with start held high
    a = 8'd10; b = 8'd10; start = 1'b1;
    tick();
    edges = 1;
    while (!done_u && edges < 20) begin tick(); edges++; end
    check("b2b_lat1", edges, 6);
    check("b2b_prod1", {16'd0, prod_u}, 32'h0064);
    a = 8'd7; b = 8'd6;
    edges = 0;
    do begin tick(); edges++; end while (!done_u && edges < 20);
    check("b2b_gap", edges, 6);
    check("b2b_prod2", {16'd0, prod_u}, 32'h002A);
    check("b2b_prod2_s", {16'd0, prod_s}, 32'h002A);
    start = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
